// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl: raster timing generator for one video mode.
// Produces h/v counters, data-valid, sync strobes, sof/eol pulses and a fetch strobe that
// leads data-valid by PRE cycles. Run/stop requests only take effect on frame boundaries.
// Optional feature: define VTC_FRAME_CNT_EN to enable the completed-frame counter.
module video_timing_ctrl #(
  parameter int unsigned HRES = 1600,
  parameter int unsigned HFP  = 24,
  parameter int unsigned HSW  = 80,
  parameter int unsigned HBP  = 96,
  parameter int unsigned VRES = 900,
  parameter int unsigned VFP  = 1,
  parameter int unsigned VSW  = 3,
  parameter int unsigned VBP  = 96,
  parameter int unsigned PRE  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_i,
  output logic        busy_o,
  output logic [10:0] h_cnt,
  output logic [10:0] v_cnt,
  output logic        vga_dv_o,
  output logic        vga_hs_o,
  output logic        vga_vs_o,
  output logic        fetch_o,
  output logic        sof_o,
  output logic        eol_o,
  output logic [15:0] frame_cnt_o
);

  localparam int unsigned HTOTAL = HRES + HFP + HSW + HBP;
  localparam int unsigned VTOTAL = VRES + VFP + VSW + VBP;

  // 12-bit thresholds so a bound equal to 2048 does not alias to 0.
  localparam logic [11:0] HResC  = 12'(HRES);
  localparam logic [11:0] VResC  = 12'(VRES);
  localparam logic [11:0] HsOnC  = 12'(HRES + HFP);
  localparam logic [11:0] HsOffC = 12'(HRES + HFP + HSW);
  localparam logic [11:0] VsOnC  = 12'(VRES + VFP);
  localparam logic [11:0] VsOffC = 12'(VRES + VFP + VSW);
  localparam logic [10:0] HTotM1 = 11'(HTOTAL - 1);
  localparam logic [10:0] VTotM1 = 11'(VTOTAL - 1);
  localparam logic [10:0] PreC   = 11'(PRE);

  if (HTOTAL > 2048 || VTOTAL > 2048 || VTOTAL < 2 || PRE < 1 || PRE > 8 || PRE >= HTOTAL)
  begin : g_param_err
    $error("video_timing_ctrl: unsupported timing parameters");
  end

  typedef enum logic [1:0] {StIdle, StRun, StStopping} state_e;

  state_e      state_q, state_d;
  logic [10:0] h_q, h_d, v_q, v_d;
  logic [10:0] la_h_q, la_h_d, la_v_q, la_v_d;  // look-ahead position, PRE pixels ahead
  logic        dv_q, dv_d, hs_q, hs_d, vs_q, vs_d;
  logic        fetch_q, fetch_d, sof_q, sof_d, eol_q, eol_d;
  logic        last_px, active, la_cross;
  logic [11:0] hx, vx, lhx, lvx;

  assign last_px = (h_q == HTotM1) && (v_q == VTotM1);

  // Next-state, counter advance and next-pixel strobe decode.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    la_h_d  = la_h_q;
    la_v_d  = la_v_q;

    case (state_q)
      StIdle:     if (run_i) state_d = StRun;
      StRun:      if (!run_i) state_d = StStopping;
      StStopping: begin
        if (run_i) state_d = StRun;
        else if (last_px) state_d = StIdle;
      end
      default:    state_d = StIdle;
    endcase

    if (state_q == StIdle || state_d == StIdle) begin
      // Parked: a start always begins at pixel 0 with the look-ahead PRE pixels in.
      h_d    = '0;
      v_d    = '0;
      la_h_d = PreC;
      la_v_d = '0;
    end else begin
      h_d = (h_q == HTotM1) ? 11'd0 : h_q + 11'd1;
      if (h_q == HTotM1) v_d = (v_q == VTotM1) ? 11'd0 : v_q + 11'd1;
      la_h_d = (la_h_q == HTotM1) ? 11'd0 : la_h_q + 11'd1;
      if (la_h_q == HTotM1) la_v_d = (la_v_q == VTotM1) ? 11'd0 : la_v_q + 11'd1;
    end

    active   = (state_d != StIdle);
    hx       = {1'b0, h_d};
    vx       = {1'b0, v_d};
    lhx      = {1'b0, la_h_d};
    lvx      = {1'b0, la_v_d};
    // Look-ahead has already wrapped into the next frame.
    la_cross = (v_d == VTotM1) && (la_v_d == 11'd0);

    dv_d    = active && (hx < HResC) && (vx < VResC);
    hs_d    = active && (hx >= HsOnC) && (hx < HsOffC);
    vs_d    = active && (vx >= VsOnC) && (vx < VsOffC);
    sof_d   = active && (h_d == 11'd0) && (v_d == 11'd0);
    eol_d   = active && (h_d == HTotM1);
    // No prefetch into a frame that a pending stop will never display.
    fetch_d = active && (lhx < HResC) && (lvx < VResC) &&
              !(la_cross && (state_d == StStopping));
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      h_q     <= '0;
      v_q     <= '0;
      la_h_q  <= PreC;
      la_v_q  <= '0;
      dv_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      fetch_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      la_h_q  <= la_h_d;
      la_v_q  <= la_v_d;
      dv_q    <= dv_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fetch_q <= fetch_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign h_cnt    = h_q;
  assign v_cnt    = v_q;
  assign vga_dv_o = dv_q;
  assign vga_hs_o = hs_q;
  assign vga_vs_o = vs_q;
  assign fetch_o  = fetch_q;
  assign sof_o    = sof_q;
  assign eol_o    = eol_q;

`ifdef VTC_FRAME_CNT_EN
  logic [15:0] frame_q;

  // Count every frame that runs to its last pixel, including the one ending a stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= '0;
    end else if (state_q != StIdle && last_px) begin
      frame_q <= frame_q + 16'd1;
    end
  end

  assign frame_cnt_o = frame_q;
`else
  assign frame_cnt_o = '0;
`endif

endmodule

// File: tb/tb_video_timing_ctrl.sv
// tb_video_timing_ctrl: directed bench for video_timing_ctrl in a small 8x6 mode.
// A behavioural raster model pushes expected outputs per cycle; fetch is checked as
// "observed fetch PRE cycles earlier equals expected data-valid now".
module tb_video_timing_ctrl;

  localparam int HT  = 8;
  localparam int VT  = 6;
  localparam int PRE = 2;
`ifdef VTC_FRAME_CNT_EN
  localparam logic [15:0] Fc3 = 16'd3;
`else
  localparam logic [15:0] Fc3 = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        run_i;
  logic        busy_o, vga_dv_o, vga_hs_o, vga_vs_o, fetch_o, sof_o, eol_o;
  logic [10:0] h_cnt, v_cnt;
  logic [15:0] frame_cnt_o;

  typedef struct packed {
    logic        busy, dv, hs, vs, sof, eol;
    logic [10:0] h, v;
    logic [15:0] fc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   m_st   = 0;  // 0 idle, 1 run, 2 stopping
  int   m_h    = 0;
  int   m_v    = 0;
  int   m_fc   = 0;
  logic obs_f  [0:2047];
  bit   busy_h [0:2047];
  bit   rst_h  [0:2047];

  video_timing_ctrl #(
    .HRES(4), .HFP(1), .HSW(2), .HBP(1), .VRES(3), .VFP(1), .VSW(1), .VBP(1), .PRE(PRE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run_i       (run_i),
    .busy_o      (busy_o),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .vga_dv_o    (vga_dv_o),
    .vga_hs_o    (vga_hs_o),
    .vga_vs_o    (vga_vs_o),
    .fetch_o     (fetch_o),
    .sof_o       (sof_o),
    .eol_o       (eol_o),
    .frame_cnt_o (frame_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Advance the model with the current inputs, clock the DUT once and compare.
  task automatic step();
    exp_t e;
    bit   last;
    bit   ok;
    if (rst) begin
      m_st = 0; m_h = 0; m_v = 0; m_fc = 0;
    end else if (m_st == 0) begin
      if (run_i) begin
        m_st = 1; m_h = 0; m_v = 0;
      end
    end else begin
      last = (m_h == HT - 1) && (m_v == VT - 1);
      if (last) m_fc = (m_fc + 1) % 65536;
      if (m_st == 2 && last && !run_i) begin
        m_st = 0; m_h = 0; m_v = 0;
      end else begin
        m_st = run_i ? 1 : 2;
        if (m_h == HT - 1) begin
          m_h = 0;
          m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end else begin
          m_h = m_h + 1;
        end
      end
    end
    e.busy = (m_st != 0);
    e.h    = 11'(m_h);
    e.v    = 11'(m_v);
    e.dv   = e.busy && m_h < 4 && m_v < 3;
    e.hs   = e.busy && (m_h == 5 || m_h == 6);
    e.vs   = e.busy && m_v == 4;
    e.sof  = e.busy && m_h == 0 && m_v == 0;
    e.eol  = e.busy && m_h == 7;
`ifdef VTC_FRAME_CNT_EN
    e.fc   = 16'(m_fc);
`else
    e.fc   = 16'd0;
`endif
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk1("busy", busy_o, e.busy);
    chkw("h_cnt", {5'b0, h_cnt}, {5'b0, e.h});
    chkw("v_cnt", {5'b0, v_cnt}, {5'b0, e.v});
    chk1("dv", vga_dv_o, e.dv);
    chk1("hs", vga_hs_o, e.hs);
    chk1("vs", vga_vs_o, e.vs);
    chk1("sof", sof_o, e.sof);
    chk1("eol", eol_o, e.eol);
    chkw("frame_cnt", frame_cnt_o, e.fc);
    if (!e.busy) chk1("fetch_idle", fetch_o, 1'b0);
    if (cyc < 2048) begin
      obs_f[cyc]  = fetch_o;
      busy_h[cyc] = e.busy;
      rst_h[cyc]  = rst;
      if (cyc >= PRE) begin
        ok = busy_h[cyc - PRE];
        for (int j = cyc - PRE + 1; j <= cyc; j++) if (rst_h[j]) ok = 0;
        if (ok) chk1("fetch_lead", obs_f[cyc - PRE], e.dv);
      end
    end
    cyc++;
  endtask

  task automatic run_until(input int h, input int v, input int limit);
    bit reached;
    reached = (m_st != 0 && m_h == h && m_v == v);
    for (int i = 0; i < limit && !reached; i++) begin
      step();
      reached = (m_st != 0 && m_h == h && m_v == v);
    end
    checks++;
    assert (reached) else begin
      errors++;
      $error("FAIL wait_pos cyc %0d: observed h=%0d v=%0d expected h=%0d v=%0d",
             cyc, m_h, m_v, h, v);
    end
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && m_st != 0; i++) step();
    checks++;
    assert (m_st == 0 && busy_o === 1'b0) else begin
      errors++;
      $error("FAIL wait_idle cyc %0d: observed busy=%b expected 0", cyc, busy_o);
    end
  endtask

  initial begin
    // T1: reset, then idle with run low.
    rst   = 1'b1;
    run_i = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    repeat (20) step();

    // T2/T3: two full frames of raster and prefetch, including frame wrap.
    run_i = 1'b1;
    repeat (96) step();

    // T4: stop request mid-frame finishes the frame, then idles.
    run_until(2, 1, 60);
    run_i = 1'b0;
    wait_idle(100);
    repeat (4) step();

    // T4: stop then re-raise during STOPPING keeps running seamlessly.
    run_i = 1'b1;
    run_until(2, 1, 60);
    run_i = 1'b0;
    run_until(0, 3, 60);
    run_i = 1'b1;
    repeat (60) step();

    // T5: reset mid-frame, then restart from pixel 0.
    run_until(3, 2, 60);
    rst = 1'b1;
    step();
    rst   = 1'b0;
    run_i = 1'b0;
    repeat (3) step();
    run_i = 1'b1;

    // T6: three complete frames after reset.
    repeat (145) step();
    chkw("frame_cnt_3", frame_cnt_o, Fc3);
    run_i = 1'b0;
    wait_idle(100);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
